// File: rtl/char_plotter.sv
// Glyph plotter: latches a 16x16 bitmap, then issues one plot request per pixel
// in raster order to the VGA adapter, with out_ready back-pressure.
module char_plotter #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [255:0]     glyph,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [C_W-1:0]   fg_colour,
    input  logic [C_W-1:0]   bg_colour,
    input  logic             transparent,
    input  logic             out_ready,
    output logic             plot,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   colour,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_cnt;
    logic [255:0]   r_glyph;
    logic [X_W-1:0] r_x0;
    logic [Y_W-1:0] r_y0;
    logic [C_W-1:0] r_fg, r_bg;
    logic           r_tr;

    logic           w_bit, w_vis, w_draw, w_adv;
    logic [X_W-1:0] w_col, w_x;
    logic [Y_W-1:0] w_row, w_y;
    logic [C_W-1:0] w_colour;

    // Current-pixel view; coordinates wrap naturally at the output widths.
    always_comb begin
        w_bit    = r_glyph[r_cnt];
        w_col    = {{(X_W-4){1'b0}}, r_cnt[3:0]};
        w_row    = {{(Y_W-4){1'b0}}, r_cnt[7:4]};
        w_x      = r_x0 + w_col;
        w_y      = r_y0 + w_row;
        w_colour = w_bit ? r_fg : r_bg;
        w_vis    = !(r_tr && !w_bit);
        w_draw   = (r_state == S_DRAW);
        // Skipped pixels advance unconditionally; visible ones wait for the sink.
        w_adv    = w_draw && (!w_vis || out_ready);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW:  if (w_adv && r_cnt == 8'd255) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_glyph <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_fg    <= '0;
            r_bg    <= '0;
            r_tr    <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_cnt   <= '0;
            r_glyph <= glyph;
            r_x0    <= x0;
            r_y0    <= y0;
            r_fg    <= fg_colour;
            r_bg    <= bg_colour;
            r_tr    <= transparent;
        end else if (w_adv) begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        plot   = w_draw && w_vis;
        x      = w_draw ? w_x      : '0;
        y      = w_draw ? w_y      : '0;
        colour = w_draw ? w_colour : '0;
        busy   = (r_state == S_DRAW) || (r_state == S_DONE);
        done   = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_char_plotter.sv
// Scoreboard bench for char_plotter: expected pixels are queued from a model
// when a draw is started and popped as the DUT presents plots.
module tb_char_plotter;

    logic         clk = 1'b0;
    logic         reset, start, transparent, out_ready;
    logic [255:0] glyph;
    logic [7:0]   x0, x;
    logic [6:0]   y0, y;
    logic [2:0]   fg_colour, bg_colour, colour;
    logic         plot, busy, done;

    int n_pass = 0;
    int n_chk  = 0;
    logic [17:0] q[$];

    char_plotter #(.X_W(8), .Y_W(7), .C_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .glyph(glyph), .x0(x0), .y0(y0),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .transparent(transparent),
        .out_ready(out_ready), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic build(input logic [255:0] g, input logic [7:0] ox, input logic [6:0] oy,
                         input logic [2:0] f, input logic [2:0] b, input logic t);
        logic [7:0] xx;
        logic [6:0] yy;
        q.delete();
        for (int i = 0; i < 256; i++) begin
            xx = ox + 8'(i % 16);
            yy = oy + 7'(i / 16);
            if (!t || g[i]) q.push_back({xx, yy, g[i] ? f : b});
        end
    endtask

    // One full draw; checks every presented plot against the queue head,
    // done timing, plot count and the return to IDLE.
    task automatic draw(input string tag, input logic [255:0] g, input logic [7:0] ox,
                        input logic [6:0] oy, input logic [2:0] f, input logic [2:0] b,
                        input logic t, input int stall_at, input int stall_n, input int restart_at);
        int acc = 0, stalls = 0, done_cyc = -1, nexp, busy_low = 0;
        build(g, ox, oy, f, b, t);
        nexp = q.size();
        @(negedge clk);
        glyph = g; x0 = ox; y0 = oy; fg_colour = f; bg_colour = b; transparent = t;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (!busy) busy_low++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (plot) begin
                chk({tag, " pix"}, 32'({x, y, colour}), q.size() != 0 ? 32'(q[0]) : 32'hdeadbeef);
                if (acc == stall_at && stalls < stall_n) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    if (q.size() != 0) void'(q.pop_front());
                    acc++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (cyc == restart_at) begin
                start = 1'b1; glyph = ~g; x0 = ox + 8'd37;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk({tag, " done cycle"}, 32'(done_cyc), 32'(257 + stall_n));
        chk({tag, " plot count"}, 32'(acc), 32'(nexp));
        chk({tag, " busy during draw"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        chk({tag, " idle after done"}, {28'd0, plot, busy, done, 1'b0}, 32'd0);
    endtask

    initial begin
        logic [255:0] gi;
        logic [255:0] gr;
        reset = 1'b1; start = 1'b0; transparent = 1'b0; out_ready = 1'b1;
        glyph = '0; x0 = '0; y0 = '0; fg_colour = '0; bg_colour = '0;
        #12;
        chk("reset outputs", 32'({plot, x, y, colour, busy, done}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", 32'({plot, busy, done}), 32'd0);

        // Solid background
        draw("solid", '0, 8'd10, 7'd20, 3'b111, 3'b001, 1'b0, -1, 0, -1);

        // Transparent 'I' glyph: 14 set bits
        gi = '0;
        for (int c = 6; c <= 8; c++) begin
            gi[3*16 + c]  = 1'b1;
            gi[12*16 + c] = 1'b1;
        end
        for (int r = 4; r <= 11; r++) gi[r*16 + 7] = 1'b1;
        draw("transparent_I", gi, 8'd0, 7'd0, 3'b111, 3'b010, 1'b1, -1, 0, -1);

        // Stall hold at pixel 17
        draw("stall", '0, 8'd40, 7'd30, 3'b100, 3'b011, 1'b0, 17, 5, -1);

        // Coordinate wrap with a random bitmap
        gr = rnd256();
        draw("wrap", gr, 8'd250, 7'd120, 3'b101, 3'b010, 1'b0, -1, 0, -1);

        // Start while busy is ignored, and a later start is accepted
        gr = rnd256();
        draw("restart_ignored", gr, 8'd5, 7'd7, 3'b110, 3'b001, 1'b0, -1, 0, 100);
        draw("after_done", ~gr, 8'd42, 7'd9, 3'b011, 3'b100, 1'b1, -1, 0, -1);

        // Reset at pixel 64
        @(negedge clk);
        glyph = rnd256(); x0 = 8'd1; y0 = 7'd2; transparent = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (64) @(negedge clk);
        chk("pre-reset plot at idx64", 32'({plot, x, y}), 32'({1'b1, 8'd1, 7'd6}));
        reset = 1'b1;
        #1;
        chk("async reset outputs", 32'({plot, busy, done}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no done after reset", 32'({plot, busy, done}), 32'd0);
        end
        gr = rnd256();
        draw("fresh_after_reset", gr, 8'd77, 7'd50, 3'b001, 3'b110, 1'b0, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/char_plotter.md
Name: char_plotter

Overview:
- Sequential consumer of the 256-bit 16x16 glyph bitmaps produced by the character decoder.
- On a start pulse it latches one glyph, a screen origin and colours, then walks all 256 pixels in raster order.
- For each pixel it issues one plot request to the VGA adapter port, with stall support.
- It sits between the character decoder and the VGA adapter and frees game logic from per-pixel drawing.

Parameters:
- X_W, 8, width of the x coordinate; the x sum wraps modulo 2^X_W.
- Y_W, 7, width of the y coordinate; the y sum wraps modulo 2^Y_W.
- C_W, 3, colour width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to draw; sampled only in IDLE.
- glyph  in  256  bitmap; pixel (col,row) = glyph[row*16+col]; row 0 top, col 0 left.
- x0  in  X_W  screen x of glyph column 0.
- y0  in  Y_W  screen y of glyph row 0.
- fg_colour  in  C_W  colour for set bits.
- bg_colour  in  C_W  colour for clear bits.
- transparent  in  1  1 = clear bits are skipped, not plotted.
- out_ready  in  1  VGA side accepts the current plot this cycle.
- plot  out  1  plot request valid.
- x  out  X_W  plot x coordinate.
- y  out  Y_W  plot y coordinate.
- colour  out  C_W  plot colour.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE, pixel counter=0, all latched regs=0, plot=0, busy=0, done=0, x=0, y=0, colour=0.
- State machine: IDLE, DRAW, DONE.
- IDLE:
  - On a clock edge with start=1, latch glyph, x0, y0, fg_colour, bg_colour and transparent; set counter=0; go to DRAW.
  - Inputs are not sampled again until the next IDLE.
- DRAW, combinational view of the current pixel:
  - idx = counter[7:0]; row = idx[7:4]; col = idx[3:0]; bit = latched glyph[idx].
  - x = x0_l + col, truncated to X_W. y = y0_l + row, truncated to Y_W.
  - colour = bit ? fg_l : bg_l.
  - plot = !(transparent_l && !bit).
- DRAW, advance rule:
  - If plot=1, the counter advances only on an edge where out_ready=1.
  - If plot=0 (skipped pixel), the counter advances unconditionally, one cycle per skipped pixel.
  - x, y and colour are stable while plot=1 and out_ready=0.
- DRAW exit: advancing from idx=255 goes to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. done=0 in all other states.
- Outside DRAW: plot=0, and x, y, colour=0.
- start while busy is ignored: no restart and no queueing.
- start in the DONE cycle is ignored; start is first accepted in the IDLE cycle that follows.
- Latency with out_ready held at 1 and transparent=0:
  - start sampled at edge E0.
  - plot high for the 256 cycles after E0.
  - done high in the 257th cycle.
  - IDLE in the 258th cycle.
- Transparent draw: total DRAW cycles = 256 + stall cycles. Skipped pixels still cost one cycle each.
- Reset asserted mid-DRAW: plot drops immediately (async). No done pulse is emitted, and the partial glyph is not resumed.
- glyph and x0 inputs may change during DRAW with no effect on the drawing.

Test Plan:
- Solid background:
  - Stimulus: glyph=0, transparent=0, x0=10, y0=20, bg=3'b001, out_ready=1, start pulse.
  - Required: 256 consecutive plots, colour=1 throughout.
  - First plot (10,20), 16th plot (25,20), 17th plot (10,21), last plot (25,35).
  - done exactly one cycle after the last plot.
- Transparent 'I' glyph:
  - Stimulus: bits set at rows 3 and 12 in cols 6-8, and at rows 4-11 in col 7. transparent=1, fg=3'b111, x0=0, y0=0.
  - Required: exactly 14 plots, all colour=7.
  - First plot (6,3), last plot (8,12).
  - done 257 cycles after start.
- Stall hold:
  - Stimulus: out_ready=0 for 5 cycles during pixel idx=17.
  - Required: plot=1 with x, y, colour frozen at (x0+1, y0+1) for those 5 cycles.
  - done 5 cycles later than in the unstalled run.
- Coordinate wrap:
  - Stimulus: x0=250, y0=120, X_W=8, Y_W=7.
  - Required: col 15 gives x=9; row 15 gives y=7. No error and no extra cycles.
- Start while busy:
  - Stimulus: second start pulse with different glyph and x0 at DRAW cycle 100.
  - Required: first draw completes unchanged and one done pulse is emitted.
  - A start asserted after done is accepted and draws the new glyph.
- Reset mid-draw:
  - Stimulus: assert reset at DRAW idx=64.
  - Required: plot, busy and done are 0 immediately, with no done pulse.
  - After reset is released, a fresh start draws all 256 pixels beginning at idx 0.
